// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder result checker.
package adder_chk_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned MAX_LATENCY = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/adder_chk_delay.sv
// LATENCY-stage shift pipeline carrying {valid, expected sum, operand index}.
module adder_chk_delay
    import adder_chk_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic [WIDTH-1:0] exp_in,
    input  logic [CNT_W-1:0] idx_in,
    output logic             tail_valid,
    output logic [WIDTH-1:0] tail_exp,
    output logic [CNT_W-1:0] tail_idx,
    output logic             any_valid
);

    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("adder_chk_delay: LATENCY out of range");
    end

    logic [LATENCY-1:0] vld;
    logic [WIDTH-1:0]   exp_q [LATENCY];
    logic [CNT_W-1:0]   idx_q [LATENCY];

    // Valid bits carry the pipeline state; flushing them empties the line.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld <= '0;
        end else begin
            vld[0] <= load;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        exp_q[0] <= exp_in;
        idx_q[0] <= idx_in;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            exp_q[i] <= exp_q[i-1];
            idx_q[i] <= idx_q[i-1];
        end
    end

    assign tail_valid = vld[LATENCY-1];
    assign tail_exp   = exp_q[LATENCY-1];
    assign tail_idx   = idx_q[LATENCY-1];
    assign any_valid  = |vld;

endmodule

// File: rtl/adder_result_checker.sv
// Self-checking sink for the registered adder: rebuilds in1+in2 through a matched
// delay line and scores it against out. ADDER_CHK_STOP_ON_FAIL_EN halts on first mismatch.
module adder_result_checker
    import adder_chk_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] fail_idx,
    output logic [WIDTH-1:0] fail_exp,
    output logic [WIDTH-1:0] fail_act
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state, state_n;
    logic [CNT_W-1:0] idx_q;
    logic             tail_valid, any_valid;
    logic [WIDTH-1:0] tail_exp;
    logic [CNT_W-1:0] tail_idx;
    logic             active, sample, cmp, miss, flush, enter_run;

    assign active    = (state == RUN) || (state == DRAIN);
    assign cmp       = active && tail_valid;
    assign miss      = cmp && (tail_exp != out);
`ifdef ADDER_CHK_STOP_ON_FAIL_EN
    assign flush     = miss;
`else
    assign flush     = 1'b0;
`endif
    assign sample    = (state == RUN) && in_valid && !flush;
    assign enter_run = (state_n == RUN) && (state != RUN);

    adder_chk_delay #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .LATENCY (LATENCY)
    ) u_delay (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (sample),
        .exp_in     (in1 + in2),
        .idx_in     (idx_q),
        .tail_valid (tail_valid),
        .tail_exp   (tail_exp),
        .tail_idx   (tail_idx),
        .any_valid  (any_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Start wins in IDLE/DONE, stop wins in RUN; a stop-on-fail flush overrides all.
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: if (start)      state_n = RUN;
            RUN:        if (stop)       state_n = DRAIN;
            DRAIN:      if (!any_valid) state_n = DONE;
            default:                    state_n = IDLE;
        endcase
        if (flush) begin
            state_n = DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            fail_idx <= '0;
            fail_exp <= '0;
            fail_act <= '0;
            idx_q    <= '0;
        end else begin
            busy <= (state_n == RUN) || (state_n == DRAIN);
            done <= (state_n == DONE);
            if (enter_run) begin
                err      <= 1'b0;
                pass_cnt <= '0;
                fail_cnt <= '0;
                fail_idx <= '0;
                fail_exp <= '0;
                fail_act <= '0;
                idx_q    <= '0;
            end else begin
                if (sample) begin
                    idx_q <= idx_q + CNT_W'(1);
                end
                if (cmp && !miss && pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + CNT_W'(1);
                end
                if (miss) begin
                    err <= 1'b1;
                    if (fail_cnt != CNT_MAX) begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                    end
                    if (!err) begin
                        fail_idx <= tail_idx;
                        fail_exp <= tail_exp;
                        fail_act <= out;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: LATENCY=1 and LATENCY=3 instances fed by a behavioural adder.
module tb_adder_result_checker;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 16;
`ifdef ADDER_CHK_STOP_ON_FAIL_EN
    localparam bit SOF = 1'b1;
`else
    localparam bit SOF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, stop, in_valid;
    logic [W-1:0]  in1, in2, mask;
    logic [W-1:0]  pipe [3];

    logic          busy_w [2];
    logic          done_w [2];
    logic          err_w  [2];
    logic [CW-1:0] pass_w [2];
    logic [CW-1:0] fail_w [2];
    logic [CW-1:0] fidx_w [2];
    logic [W-1:0]  fexp_w [2];
    logic [W-1:0]  fact_w [2];

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    // Registered adder with an injectable corruption mask on its result.
    always @(posedge clk) begin
        pipe[0] <= (in1 + in2) ^ mask;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end

    adder_result_checker #(.WIDTH(W), .LATENCY(1), .CNT_W(CW)) u_l1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
        .in1(in1), .in2(in2), .out(pipe[0]),
        .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
        .pass_cnt(pass_w[0]), .fail_cnt(fail_w[0]), .fail_idx(fidx_w[0]),
        .fail_exp(fexp_w[0]), .fail_act(fact_w[0])
    );

    adder_result_checker #(.WIDTH(W), .LATENCY(3), .CNT_W(CW)) u_l3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
        .in1(in1), .in2(in2), .out(pipe[2]),
        .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
        .pass_cnt(pass_w[1]), .fail_cnt(fail_w[1]), .fail_idx(fidx_w[1]),
        .fail_exp(fexp_w[1]), .fail_act(fact_w[1])
    );

    // Model: each accepted operand becomes a scheduled report LATENCY edges later.
    typedef struct {
        int            due;
        logic [W-1:0]  e;
        logic [W-1:0]  a;
        logic [CW-1:0] i;
    } ent_t;

    ent_t          pend [2][$];
    int            mst  [2];
    logic [CW-1:0] mpass[2], mfail[2], mfidx[2], midx[2];
    logic          merr [2];
    logic [W-1:0]  mfexp[2], mfact[2];
    int            cyc = 0;

    always @(posedge clk) begin
        ent_t         en;
        bit           fn;
        int           nst;
        int           lat;
        logic [W-1:0] s;
        cyc++;
        for (int m = 0; m < 2; m++) begin
            lat = (m == 0) ? 1 : 3;
            if (rst) begin
                mst[m] = 0; pend[m].delete();
                mpass[m] = '0; mfail[m] = '0; mfidx[m] = '0; midx[m] = '0;
                merr[m] = 1'b0; mfexp[m] = '0; mfact[m] = '0;
            end else begin
                fn  = 1'b0;
                nst = mst[m];
                case (mst[m])
                    0, 3: if (start) nst = 1;
                    1:    if (stop)  nst = 2;
                    2:    if (pend[m].size() == 0) nst = 3;
                    default: nst = 0;
                endcase
                if ((mst[m] == 1 || mst[m] == 2) && pend[m].size() > 0 && pend[m][0].due == cyc) begin
                    en = pend[m].pop_front();
                    if (en.e == en.a) begin
                        if (mpass[m] != 16'hFFFF) mpass[m]++;
                    end else begin
                        if (!merr[m]) begin
                            mfidx[m] = en.i; mfexp[m] = en.e; mfact[m] = en.a;
                        end
                        merr[m] = 1'b1;
                        if (mfail[m] != 16'hFFFF) mfail[m]++;
                        fn = 1'b1;
                    end
                end
                if (SOF && fn) begin
                    nst = 3;
                    pend[m].delete();
                end else if (mst[m] == 1 && in_valid) begin
                    s = in1 + in2;
                    pend[m].push_back('{cyc + lat, s, s ^ mask, midx[m]});
                    midx[m]++;
                end
                if (nst == 1 && mst[m] != 1) begin
                    mpass[m] = '0; mfail[m] = '0; mfidx[m] = '0; midx[m] = '0;
                    merr[m] = 1'b0; mfexp[m] = '0; mfact[m] = '0;
                end
                mst[m] = nst;
            end
        end
    end

    task automatic chk(input string nm, input int m, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s L%0d got %0h expected %0h (t=%0t)", nm, (m == 0) ? 1 : 3, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int m = 0; m < 2; m++) begin
                chk("busy",     m, 64'(busy_w[m]), 64'(mst[m] == 1 || mst[m] == 2));
                chk("done",     m, 64'(done_w[m]), 64'(mst[m] == 3));
                chk("err",      m, 64'(err_w[m]),  64'(merr[m]));
                chk("pass_cnt", m, 64'(pass_w[m]), 64'(mpass[m]));
                chk("fail_cnt", m, 64'(fail_w[m]), 64'(mfail[m]));
                chk("fail_idx", m, 64'(fidx_w[m]), 64'(mfidx[m]));
                chk("fail_exp", m, 64'(fexp_w[m]), 64'(mfexp[m]));
                chk("fail_act", m, 64'(fact_w[m]), 64'(mfact[m]));
            end
        end
    end

    task automatic drv(input logic s, input logic p, input logic v,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] mk);
        start = s; stop = p; in_valid = v; in1 = a; in2 = b; mask = mk;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wait_done3(input string nm);
        int k;
        k = 0;
        while (!done_w[1] && k < 20) begin
            idle(1);
            k++;
        end
        chk(nm, 1, 64'(done_w[1]), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        in1 = '0; in2 = '0; mask = '0;
        idle(2);
        chk_on = 1'b1;
        rst = 1'b0;
        chk("rst_pass", 0, 64'(pass_w[0]), 64'd0);
        chk("rst_busy", 1, 64'(busy_w[1]), 64'd0);
        chk("rst_done", 1, 64'(done_w[1]), 64'd0);

        // Basic add, octal operand, and carry-out wrap.
        drv(1'b1, 1'b0, 1'b0, '0, '0, '0);
        chk("start_busy", 0, 64'(busy_w[0]), 64'd1);
        drv(1'b0, 1'b0, 1'b1, 32'h631, 32'd341, '0);
        idle(1);
        chk("t1_pass", 0, 64'(pass_w[0]), 64'd1);
        idle(2);
        chk("t1_pass", 1, 64'(pass_w[1]), 64'd1);
        drv(1'b0, 1'b0, 1'b1, 32'o1461, 32'd0, '0);
        drv(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, '0);
        idle(3);
        chk("t2_pass", 0, 64'(pass_w[0]), 64'd3);
        chk("t2_pass", 1, 64'(pass_w[1]), 64'd3);
        chk("t2_fail", 1, 64'(fail_w[1]), 64'd0);
        drv(1'b0, 1'b1, 1'b0, '0, '0, '0);
        idle(5);
        chk("t2_done", 1, 64'(done_w[1]), 64'd1);

        // Corrupt index 1 (exp 10, act 11), then a later mismatch.
        drv(1'b1, 1'b0, 1'b0, '0, '0, '0);
        chk("restart_clr", 0, 64'(pass_w[0]), 64'd0);
        drv(1'b0, 1'b0, 1'b1, 32'd3, 32'd4, '0);
        drv(1'b0, 1'b0, 1'b1, 32'd4, 32'd6, 32'd1);
        drv(1'b0, 1'b0, 1'b1, 32'd5, 32'd5, '0);
        idle(3);
        chk("t3_fail",  0, 64'(fail_w[0]), 64'd1);
        chk("t3_err",   0, 64'(err_w[0]),  64'd1);
        chk("t3_fidx",  0, 64'(fidx_w[0]), 64'd1);
        chk("t3_fexp",  0, 64'(fexp_w[0]), 64'd10);
        chk("t3_fact",  0, 64'(fact_w[0]), 64'd11);
        chk("t3_pass",  0, 64'(pass_w[0]), SOF ? 64'd1 : 64'd2);
        chk("t3_fidx",  1, 64'(fidx_w[1]), 64'd1);
        drv(1'b0, 1'b0, 1'b1, 32'd1, 32'd1, 32'd4);
        idle(3);
        chk("t3_fail2", 0, 64'(fail_w[0]), SOF ? 64'd1 : 64'd2);
        chk("t3_keep",  0, 64'(fidx_w[0]), 64'd1);
        chk("t3_keepx", 0, 64'(fact_w[0]), 64'd11);
        drv(1'b0, 1'b1, 1'b0, '0, '0, '0);
        idle(5);

        // Drain with LATENCY=3: stop one cycle after last operand.
        drv(1'b1, 1'b0, 1'b0, '0, '0, '0);
        drv(1'b0, 1'b0, 1'b1, 32'd1, 32'd1, '0);
        drv(1'b0, 1'b0, 1'b1, 32'd2, 32'd2, '0);
        drv(1'b0, 1'b1, 1'b0, '0, '0, '0);
        chk("t4_busy", 1, 64'(busy_w[1]), 64'd1);
        wait_done3("t4_drain_to");
        chk("t4_pass", 1, 64'(pass_w[1]), 64'd2);

        // Reset with entries in flight.
        drv(1'b1, 1'b0, 1'b0, '0, '0, '0);
        drv(1'b0, 1'b0, 1'b1, 32'd7, 32'd8, '0);
        drv(1'b0, 1'b0, 1'b1, 32'd9, 32'd9, '0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t5_pass", 0, 64'(pass_w[0]), 64'd0);
        chk("t5_busy", 1, 64'(busy_w[1]), 64'd0);
        idle(4);
        chk("t5_quiet", 1, 64'(pass_w[1]), 64'd0);

        // First of four back-to-back operands mismatches.
        drv(1'b1, 1'b0, 1'b0, '0, '0, '0);
        drv(1'b0, 1'b0, 1'b1, 32'd1, 32'd2, 32'd8);
        drv(1'b0, 1'b0, 1'b1, 32'd2, 32'd2, '0);
        chk("t6_err",  0, 64'(err_w[0]),  64'd1);
        chk("t6_done", 0, 64'(done_w[0]), SOF ? 64'd1 : 64'd0);
        drv(1'b0, 1'b0, 1'b1, 32'd3, 32'd3, '0);
        drv(1'b0, 1'b0, 1'b1, 32'd4, 32'd4, '0);
        drv(1'b0, 1'b1, 1'b0, '0, '0, '0);
        wait_done3("t6_drain_to");
        chk("t6_pass", 0, 64'(pass_w[0]), SOF ? 64'd0 : 64'd3);
        chk("t6_fail", 0, 64'(fail_w[0]), 64'd1);
        chk("t6_pass", 1, 64'(pass_w[1]), SOF ? 64'd0 : 64'd3);
        chk("t6_fexp", 1, 64'(fexp_w[1]), 64'd3);
        chk("t6_fact", 1, 64'(fact_w[1]), 64'd11);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Hardware self-checking sink at the result end of the registered `adder`.
- Samples the same operands driven into the adder and builds the expected sum through a delay line matched to adder latency.
- Compares that sum against the adder `out` and keeps pass/fail counts, a sticky error flag and a capture of the first mismatch.
- Sits beside the adder in benches and in on-chip BIST wrappers. Replaces `$display`-based checking.

Parameters:
- WIDTH, 32, operand/result width (matches adder in1/in2/out).
- LATENCY, 1, adder cycles from operand sample to valid out; legal 1..8.
- CNT_W, 16, width of pass/fail/index counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse: clear stats, enter RUN.
- stop  input  1  pulse: stop accepting operands, drain pipeline.
- in_valid  input  1  in1/in2 presented to adder this cycle.
- in1  input  WIDTH  operand A (same net as adder in1).
- in2  input  WIDTH  operand B (same net as adder in2).
- out  input  WIDTH  adder result.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE.
- err  output  1  sticky, any mismatch since start.
- pass_cnt  output  CNT_W  matching results, saturating.
- fail_cnt  output  CNT_W  mismatching results, saturating.
- fail_idx  output  CNT_W  operand index (0-based) of first mismatch.
- fail_exp  output  WIDTH  expected value of first mismatch.
- fail_act  output  WIDTH  actual out of first mismatch.

Behaviour:
- Reset (`rst`=1 at posedge): state IDLE, delay line emptied, all outputs 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN on start.
  - RUN→DRAIN on stop.
  - DRAIN→DONE when no valid entry remains in the delay line.
  - DONE→RUN on start.
  - start in RUN/DRAIN: ignored.
  - stop outside RUN: ignored.
  - start and stop in the same cycle: start wins in IDLE/DONE, stop wins in RUN.
- Entering RUN clears counters, err, fail_* and the operand index in the same edge.
- Operand sampling happens only in RUN with in_valid=1:
  - exp = (in1 + in2) mod 2^WIDTH; carry is discarded.
  - {valid, exp, index} enters stage 0. The index counter increments and wraps at 2^CNT_W.
- Delay line: LATENCY stages, advancing every cycle unconditionally, with no backpressure.
- At the last stage with valid=1, compare against current out. Counters, err and fail_* update at the following posedge (1-cycle report latency):
  - match: pass_cnt++.
  - mismatch: fail_cnt++ and err←1. The first mismatch only loads fail_idx/fail_exp/fail_act; later mismatches leave them unchanged.
  - Counters saturate at all-ones.
- In DRAIN, no new operands are sampled (in_valid ignored), but in-flight entries are still compared.
- rst mid-operation discards in-flight entries. No compare is reported for them.
- in_valid outside RUN: no effect.

Optional Feature:
- Macro: ADDER_CHK_STOP_ON_FAIL_EN.
- Defined: the first mismatch forces RUN/DRAIN→DONE at the same edge that sets err. Remaining in-flight entries are flushed uncompared, and pass_cnt freezes.
- Undefined: mismatches are counted and operation continues until stop/drain completes.

Decomposition:
- Package adder_chk_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - default WIDTH/CNT_W constants;
  - MAX_LATENCY=8.
- One sub-module, adder_chk_delay: parameterised LATENCY-stage shift pipeline carrying {valid, exp, index}, with synchronous flush input.

Test Plan:
- Reset, then start; in_valid with in1=32'h631, in2=341; out=1926 one cycle later → pass_cnt=1, fail_cnt=0, err=0.
- in1=32'o1461, in2=0, out=32'h331 → pass_cnt increments; then in1=32'hFFFFFFFF, in2=2, out=1 → pass (wrap-around, carry dropped).
- Three valid operands at indices 0,1,2; corrupt out on index 1 (exp 10, act 11) → fail_cnt=1, err=1, fail_idx=1, fail_exp=10, fail_act=11; a later mismatch leaves fail_* unchanged.
- LATENCY=3: stop asserted one cycle after the last in_valid → busy stays high until the last compare, then done=1; the final result is still counted.
- Assert rst while two entries are in flight → all outputs 0, state IDLE, no compare reported afterwards.
- With ADDER_CHK_STOP_ON_FAIL_EN: mismatch on the first of 4 back-to-back operands → done=1 at the err edge, pass_cnt=0, fail_cnt=1. Without the macro → pass_cnt=3, fail_cnt=1.
